controller_serial_multi: RTL

- Parametrised successor to the single-pad NES reader.
- Polls NUM_PADS serial game controllers in parallel over a shared latch/pulse pair. Each pad returns NUM_BITS bits: 8 for NES, 16 for SNES.
- Outputs debounced-per-frame button vectors plus newly-pressed edge flags to the game logic.
- Sits between the controller port pins and the game state machine.

---
 rtl/controller_serial_multi.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/controller_serial_multi.sv
// Multi-pad serial controller reader (NES/SNES style) with shared latch/pulse and per-frame edge flags.
// Optional auto-polling is enabled by defining CTRL_AUTO_POLL_EN (adds auto_en port and POLL_GAP).
module controller_serial_multi #(
    parameter int unsigned NUM_PADS   = 2,
    parameter int unsigned NUM_BITS   = 8,
    parameter int unsigned CLK_DIV    = 6,
    parameter int unsigned LATCH_HALF = 2
`ifdef CTRL_AUTO_POLL_EN
    ,
    parameter int unsigned POLL_GAP   = 1000
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
`ifdef CTRL_AUTO_POLL_EN
    input  logic                         auto_en,
`endif
    input  logic [NUM_PADS-1:0]          data_in,
    output logic                         latch_out,
    output logic                         pulse_out,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons_pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons_new,
    output logic                         valid,
    output logic                         busy
);

    localparam int unsigned W     = NUM_PADS * NUM_BITS;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned LH_W  = (LATCH_HALF > 1) ? $clog2(LATCH_HALF) : 1;

    typedef enum logic [1:0] {StIdle, StLatch, StReadLo, StReadHi} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [LH_W-1:0]  half_q, half_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     pressed_q, pressed_d;
    logic [W-1:0]     new_q, new_d;
    logic [W-1:0]     merged;
    logic             valid_q, valid_d;
    logic             latch_q, pulse_q, busy_q;
    logic             tick;
    logic             auto_fire;

`ifdef CTRL_AUTO_POLL_EN
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;

    assign auto_fire = auto_en && (state_q == StIdle) && (gap_q == GAP_W'(POLL_GAP - 1));

    always_comb begin
        gap_d = gap_q + GAP_W'(1);
        if (!auto_en || (state_q != StIdle) || start || auto_fire) begin
            gap_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // Shadow with the bit currently on the wire folded in, so the last bit lands in the frame result.
    always_comb begin
        merged = shadow_q;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            merged[p * NUM_BITS + 32'(bit_q)] = ~data_in[p];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        half_d    = half_q;
        shadow_d  = shadow_q;
        pressed_d = pressed_q;
        new_d     = new_q;
        valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start || auto_fire) begin
                    state_d = StLatch;
                    half_d  = '0;
                    bit_d   = '0;
                end
            end
            StLatch: begin
                if (tick) begin
                    if (half_q == LH_W'(LATCH_HALF - 1)) begin
                        state_d = StReadLo;
                        bit_d   = '0;
                    end else begin
                        half_d = half_q + LH_W'(1);
                    end
                end
            end
            StReadLo: begin
                if (tick) begin
                    shadow_d = merged;
                    if (bit_q == BIT_W'(NUM_BITS - 1)) begin
                        state_d   = StIdle;
                        pressed_d = merged;
                        new_d     = merged & ~pressed_q;
                        valid_d   = 1'b1;
                    end else begin
                        state_d = StReadHi;
                    end
                end
            end
            StReadHi: begin
                if (tick) begin
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = StReadLo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Divider restarts on every state change so each phase gets a full CLK_DIV period.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if ((state_q == StIdle) || (state_d != state_q) || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            half_q    <= '0;
            shadow_q  <= '0;
            pressed_q <= '0;
            new_q     <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            pressed_q <= pressed_d;
            new_q     <= new_d;
            valid_q   <= valid_d;
            latch_q   <= (state_d == StLatch);
            pulse_q   <= (state_d == StReadHi);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign latch_out       = latch_q;
    assign pulse_out       = pulse_q;
    assign busy            = busy_q;
    assign valid           = valid_q;
    assign buttons_pressed = pressed_q;
    assign buttons_new     = new_q;

endmodule
